seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width; SHALL be an even value of at least 8.
REQ-002 Parameter BITS_PER_CYCLE, default 1: multiplier bits retired per cycle; SHALL be 1, 2 or 4 and SHALL divide WIDTH.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: reset; it is synchronous and active-high.
REQ-005 Ports a_i and b_i, input, WIDTH: multiplicand and multiplier.
REQ-006 Port op_i, input, 2: mult_op_e: MUL=0 (low word), MULH=1 (signed x signed, high word), MULHSU=2 (signed a x unsigned b, high word), MULHU=3 (unsigned x unsigned, high word).
REQ-007 Ports in_valid_i (input, 1) and in_ready_o (output, 1): input handshake.
REQ-008 Port flush_i, input, 1: abort the current operation.
REQ-009 Port result_o, output, WIDTH: the selected product word.
REQ-010 Ports out_valid_o (output, 1) and out_ready_i (input, 1): output handshake.

Function
REQ-011 Datapath SHALL use a 3-state FSM: IDLE, BUSY, DONE.
REQ-012 in_ready_o SHALL be 1 only in IDLE; out_valid_o SHALL be 1 only in DONE.
REQ-013 Accept: on an edge with in_valid_i=1 in IDLE, the block SHALL register the operand magnitudes, the result sign (neg), op_i, and count=N, where N=WIDTH/BITS_PER_CYCLE, and enter BUSY.
REQ-014 Signedness: a SHALL be treated as signed for MULH and MULHSU; b SHALL be treated as signed for MULH only; neg SHALL be the XOR of the signed operands' sign bits.
REQ-015 Each BUSY edge SHALL add the shifted magnitude partial products for BITS_PER_CYCLE multiplier bits into a 2*WIDTH accumulator and decrement count.
REQ-016 On the BUSY edge with count=1, the block SHALL load result_o with the 2's complement of the accumulator when neg=1, select bits [WIDTH-1:0] for MUL and [2*WIDTH-1:WIDTH] otherwise, and enter DONE.
REQ-017 Latency: out_valid_o SHALL rise N edges after the accepting edge, which is 32 for the defaults.
REQ-018 In DONE, result_o and out_valid_o SHALL hold stable until an edge with out_ready_i=1, which SHALL return the FSM to IDLE.
REQ-019 in_valid_i SHALL be ignored outside IDLE; a back-to-back operation SHALL start no sooner than one cycle after output completion.
REQ-020 flush_i=1 SHALL force IDLE on the next edge from any state and drop out_valid_o; it SHALL take priority over accept, step and output handshake; an in_valid_i that arrives alongside flush_i SHALL NOT be accepted.
REQ-021 The most negative operand (0x80000000 at WIDTH=32) SHALL produce a correct result, so magnitudes SHALL be WIDTH+1 bits wide where needed.
REQ-022 result_o SHALL be 0 outside DONE.

Reset
REQ-023 rst=1 SHALL set state=IDLE, count=0, the accumulator and result_o to 0, out_valid_o=0 and in_ready_o=1 on the next edge.
REQ-024 Reset mid-operation SHALL discard all operation state; no out_valid_o SHALL follow.
REQ-025 rst SHALL have priority over flush_i and all handshakes.

Configuration
REQ-026 Macro SEQ_MULT_ZERO_SKIP_EN, when defined: if either accepted operand is 0, the FSM SHALL go IDLE->DONE on the accepting edge with result_o=0, giving a latency of 1 edge.
REQ-027 Without SEQ_MULT_ZERO_SKIP_EN, zero operands SHALL take the full N-cycle latency with result 0.

Structure
REQ-028 Package seq_mult_pkg SHALL hold the mult_op_e enum, the FSM state enum and the localparam encodings.
REQ-029 Sub-module mult_radix_step, which is combinational, SHALL compute accumulator + (BITS_PER_CYCLE-bit multiplier slice x multiplicand, shifted) for one step.

Verification (WIDTH=32, BITS_PER_CYCLE=1 unless stated)
REQ-030 MUL 7x6 -> result_o=42, out_valid_o 32 edges after accept, in_ready_o=0 throughout.
REQ-031 0xFFFFFFFF x 0xFFFFFFFF -> MUL=0x00000001, MULH=0x00000000, MULHSU=0xFFFFFFFF, MULHU=0xFFFFFFFE.
REQ-032 MULH 0x80000000 x 0x80000000 -> 0x40000000; MUL 0x80000000 x 0xFFFFFFFF -> 0x80000000.
REQ-033 Hold out_ready_i=0 for 5 cycles in DONE -> result_o and out_valid_o stable; in_valid_i pulses ignored; IDLE one edge after out_ready_i=1.
REQ-034 flush_i at count=10, then rst at count=20 of a new operation -> IDLE next edge, out_valid_o never asserted, and the following MUL 3x5 yields 15.
REQ-035 BITS_PER_CYCLE=4, MULHU 0x12345678 x 0x9ABCDEF0 -> 0x0B00EA4E after 8 edges; with SEQ_MULT_ZERO_SKIP_EN, MUL 0 x 5 -> 0 after 1 edge.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared types for the sequential multiplier: operation and FSM encodings,
// plus helpers that decide operand signedness from the operation.
package seq_mult_pkg;

    localparam int unsigned OP_W    = 2;
    localparam int unsigned STATE_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_MUL    = 2'd0,
        OP_MULH   = 2'd1,
        OP_MULHSU = 2'd2,
        OP_MULHU  = 2'd3
    } mult_op_e;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mult_state_e;

    function automatic logic a_is_signed(input mult_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU);
    endfunction

    function automatic logic b_is_signed(input mult_op_e op);
        return (op == OP_MULH);
    endfunction

endpackage

// File: rtl/mult_radix_step.sv
// One multiply step: adds slice x multiplicand (pre-shifted by the caller)
// into the running double-width accumulator.
module mult_radix_step #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [2*WIDTH-1:0]        acc_i,
    input  logic [2*WIDTH-1:0]        mcand_i,
    input  logic [BITS_PER_CYCLE-1:0] slice_i,
    output logic [2*WIDTH-1:0]        sum_o
);

    always_comb begin
        sum_o = acc_i;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (slice_i[i]) begin
                sum_o = sum_o + (mcand_i << i);
            end
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative sign-magnitude multiplier retiring BITS_PER_CYCLE bits per cycle.
// Define SEQ_MULT_ZERO_SKIP_EN to finish zero-operand requests in one edge.
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [1:0]       op_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             flush_i,
    output logic [WIDTH-1:0] result_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    mult_state_e        state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               neg_q, neg_d;
    mult_op_e           op_q, op_d;
    logic [WIDTH-1:0]   result_q, result_d;

    mult_op_e           op_in;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] step_sum;
    logic [2*WIDTH-1:0] prod;

    // Magnitude of the most negative value wraps to itself, which is the
    // correct unsigned magnitude in WIDTH bits.
    assign op_in = mult_op_e'(op_i);
    assign a_neg = a_is_signed(op_in) & a_i[WIDTH-1];
    assign b_neg = b_is_signed(op_in) & b_i[WIDTH-1];
    assign a_mag = a_neg ? -a_i : a_i;
    assign b_mag = b_neg ? -b_i : b_i;

    mult_radix_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .slice_i (mplier_q[BITS_PER_CYCLE-1:0]),
        .sum_o   (step_sum)
    );

    assign prod = neg_q ? -step_sum : step_sum;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        op_d     = op_q;
        result_d = result_q;
        if (flush_i) begin
            state_d  = ST_IDLE;
            count_d  = '0;
            acc_d    = '0;
            result_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        mcand_d  = {{WIDTH{1'b0}}, a_mag};
                        mplier_d = b_mag;
                        neg_d    = a_neg ^ b_neg;
                        op_d     = op_in;
                        acc_d    = '0;
                        count_d  = CW'(N);
                        state_d  = ST_BUSY;
`ifdef SEQ_MULT_ZERO_SKIP_EN
                        if ((a_i == '0) || (b_i == '0)) begin
                            count_d  = '0;
                            result_d = '0;
                            state_d  = ST_DONE;
                        end
`endif
                    end
                end
                ST_BUSY: begin
                    acc_d    = step_sum;
                    mcand_d  = mcand_q << BITS_PER_CYCLE;
                    mplier_d = mplier_q >> BITS_PER_CYCLE;
                    count_d  = count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        result_d = (op_q == OP_MUL) ? prod[WIDTH-1:0]
                                                    : prod[2*WIDTH-1:WIDTH];
                        state_d  = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        acc_d    = '0;
                        result_d = '0;
                        state_d  = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            op_q     <= OP_MUL;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    assign in_ready_o  = (state_q == ST_IDLE);
    assign out_valid_o = (state_q == ST_DONE);
    assign result_o    = result_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench: vector table plus scoreboard, handshake corner cases,
// and a 4-bits-per-cycle instance.
module tb_seq_multiplier;

    localparam int N = 32;
`ifdef SEQ_MULT_ZERO_SKIP_EN
    localparam int ZLAT = 0;
`else
    localparam int ZLAT = N;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] a, b, result;
    logic [1:0]  op;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a4, b4, result4;
    logic [1:0]  op4;
    logic        in_valid4, in_ready4, out_valid4, out_ready4;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut (
        .clk(clk), .rst(rst), .a_i(a), .b_i(b), .op_i(op),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .flush_i(flush),
        .result_o(result), .out_valid_o(out_valid), .out_ready_i(out_ready)
    );

    seq_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst), .a_i(a4), .b_i(b4), .op_i(op4),
        .in_valid_i(in_valid4), .in_ready_o(in_ready4), .flush_i(flush),
        .result_o(result4), .out_valid_o(out_valid4), .out_ready_i(out_ready4)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        logic [63:0] xe, ye, p;
        xe = (o == 2'd1 || o == 2'd2) ? {{32{x[31]}}, x} : {32'd0, x};
        ye = (o == 2'd1) ? {{32{y[31]}}, y} : {32'd0, y};
        p  = xe * ye;
        return (o == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // Called on a negedge with the DUT idle; returns on a negedge, idle again.
    task automatic run_op(input string name, input logic [1:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        int rdy_seen;
        logic [31:0] want;
        check({name, " in_ready before"}, 32'(in_ready), 32'd1);
        op = o; a = x; b = y; in_valid = 1'b1;
        sb.push_back(exp);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        rdy_seen = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_seen++;
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " in_ready while busy"}, 32'(rdy_seen), 32'd0);
        want = sb.pop_front();
        check({name, " result"}, out_valid ? result : 32'hxxxxxxxx, want);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " out_valid after pop"}, 32'(out_valid), 32'd0);
        check({name, " result after pop"}, result, 32'd0);
    endtask

    vec_t vecs[10];

    initial begin
        logic [31:0] hold_res;
        int cnt;
        vecs[0] = '{2'd0, 32'd7,        32'd6,        32'd42,       N};
        vecs[1] = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, N};
        vecs[2] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, N};
        vecs[3] = '{2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, N};
        vecs[4] = '{2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, N};
        vecs[5] = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000, N};
        vecs[6] = '{2'd0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, N};
        vecs[7] = '{2'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, N};
        vecs[8] = '{2'd3, 32'h80000000, 32'd4,        32'h00000002, N};
        vecs[9] = '{2'd0, 32'd0,        32'd5,        32'd0,        ZLAT};

        rst = 1'b1; flush = 1'b0;
        a = '0; b = '0; op = '0; in_valid = 1'b0; out_ready = 1'b0;
        a4 = '0; b4 = '0; op4 = '0; in_valid4 = 1'b0; out_ready4 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a,
                   vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        for (int i = 0; i < 6; i++) begin
            logic [31:0] x, y;
            logic [1:0] o;
            x = $urandom;
            y = $urandom;
            o = 2'($urandom_range(0, 3));
            if (x == 0) x = 32'd1;
            if (y == 0) y = 32'd1;
            run_op($sformatf("rand%0d", i), o, x, y, model(o, x, y), N);
        end

        // Output held in DONE while the consumer stalls
        op = 2'd0; a = 32'd9; b = 32'd11; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("hold latency", 32'(cnt), 32'(N));
        hold_res = result;
        check("hold result", hold_res, 32'd99);
        for (int i = 0; i < 5; i++) begin
            a = 32'd2; b = 32'd2; in_valid = (i % 2 == 0);
            @(negedge clk);
            check($sformatf("hold stable %0d", i), result, hold_res);
            check($sformatf("hold valid %0d", i), 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("hold released idle", 32'(in_ready), 32'd1);
        check("hold released valid", 32'(out_valid), 32'd0);

        // Flush mid-operation, with a simultaneous in_valid
        op = 2'd0; a = 32'd100; b = 32'd100; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (22) @(negedge clk);
        flush = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("flush idle", 32'(in_ready), 32'd1);
        check("flush valid", 32'(out_valid), 32'd0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid || !in_ready) cnt++;
        end
        check("flush no output", 32'(cnt), 32'd0);

        // Reset mid-operation beats in_valid
        op = 2'd0; a = 32'd100; b = 32'd100; in_valid = 1'b1;
        @(negedge clk);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        check("rst idle", 32'(in_ready), 32'd1);
        check("rst result", result, 32'd0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("rst no output", 32'(cnt), 32'd0);
        run_op("after rst", 2'd0, 32'd3, 32'd5, 32'd15, N);

        // Four bits per cycle
        op4 = 2'd3; a4 = 32'h12345678; b4 = 32'h9ABCDEF0; in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        cnt = 0;
        while (!out_valid4 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("r4 latency", 32'(cnt), 32'd8);
        check("r4 result", result4, 32'h0B00EA4E);
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
        check("r4 idle", 32'(in_ready4), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
